// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Requester-side bundle for sram_arbiter: loader (write-only), video
//   (read-only) and CPU (read/write) channels.
//   Ports per channel:
//     ldReq/ldAddr/ldD   -> arbiter, ldAck <- arbiter
//     vdReq/vdAddr       -> arbiter, vdAck/vdQ <- arbiter
//     cpuReq/cpuWe/cpuAddr/cpuD -> arbiter, cpuAck/cpuQ <- arbiter
//   Addresses are byte addresses, ADDR_WIDTH+1 bits wide.
//   master modport: requester side; slave modport: arbiter side.
interface sram_arbiter_if #(
  parameter int ADDR_WIDTH = 21
);
  logic                ldReq;
  logic                ldAck;
  logic [ADDR_WIDTH:0] ldAddr;
  logic [7:0]          ldD;

  logic                vdReq;
  logic                vdAck;
  logic [ADDR_WIDTH:0] vdAddr;
  logic [7:0]          vdQ;

  logic                cpuReq;
  logic                cpuWe;
  logic                cpuAck;
  logic [ADDR_WIDTH:0] cpuAddr;
  logic [7:0]          cpuD;
  logic [7:0]          cpuQ;

  modport master (
    output ldReq, ldAddr, ldD,
    output vdReq, vdAddr,
    output cpuReq, cpuWe, cpuAddr, cpuD,
    input  ldAck, vdAck, vdQ, cpuAck, cpuQ
  );

  modport slave (
    input  ldReq, ldAddr, ldD,
    input  vdReq, vdAddr,
    input  cpuReq, cpuWe, cpuAddr, cpuD,
    output ldAck, vdAck, vdQ, cpuAck, cpuQ
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one 16-bit asynchronous SRAM between a loader, a video reader and
//   a CPU. Each access is byte wide: the byte address LSB picks the lane.
//   Ports:
//     clock, reset_n      system clock (rising edge), async active-low reset
//     bus                 sram_arbiter_if.slave requester channels
//     sramUb/Lb/Oe/We     active-low SRAM strobes
//     sramA               SRAM word address (registered, holds when idle)
//     sramDq              SRAM data bus (driven only for writes)
//   Parameters: ADDR_WIDTH (word address width), WAIT_STATES (1..15 ACCESS
//   cycles per access).
//   Build option: define SRAM_ARB_RR_EN to resolve video/CPU contention
//   round-robin; otherwise video always beats the CPU. Loader always wins.
//
//   state  | meaning
//   IDLE   | waiting for a request; grant is taken on the edge leaving IDLE
//   ACCESS | strobes active for WAIT_STATES cycles; read byte captured on last
//   DONE   | one-cycle ack to granted channel; write data still driven
module sram_arbiter #(
  parameter int ADDR_WIDTH  = 21,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  sram_arbiter_if.slave         bus,
  output logic                  sramUb,
  output logic                  sramLb,
  output logic                  sramOe,
  output logic                  sramWe,
  output logic [ADDR_WIDTH-1:0] sramA,
  inout  wire  [15:0]           sramDq
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

  localparam logic [1:0] CH_LD  = 2'd0;
  localparam logic [1:0] CH_VD  = 2'd1;
  localparam logic [1:0] CH_CPU = 2'd2;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  stateT               state, nextState;
  logic [3:0]          waitCnt;
  logic [1:0]          curCh;
  logic                curWrite;
  logic                curLaneHi;
  logic [7:0]          curData;
  logic [7:0]          vdQReg, cpuQReg;

  logic                anyReq;
  logic [1:0]          grantCh;
  logic [ADDR_WIDTH:0] grantAddr;
  logic                grantWrite;
  logic [7:0]          grantData;
  logic                driveDq;
  logic                ldAckC, vdAckC, cpuAckC;
  logic [7:0]          laneByte;

`ifdef SRAM_ARB_RR_EN
  // 0: video wins the next contention, 1: CPU wins it
  logic rrPtr;
`endif

  assign anyReq = bus.ldReq | bus.vdReq | bus.cpuReq;

  always_comb begin
    grantCh = CH_LD;
    if (bus.ldReq)
      grantCh = CH_LD;
`ifdef SRAM_ARB_RR_EN
    else if (bus.vdReq && bus.cpuReq)
      grantCh = rrPtr ? CH_CPU : CH_VD;
`endif
    else if (bus.vdReq)
      grantCh = CH_VD;
    else if (bus.cpuReq)
      grantCh = CH_CPU;
  end

  always_comb begin
    grantAddr  = bus.cpuAddr;
    grantWrite = bus.cpuWe;
    grantData  = bus.cpuD;
    case (grantCh)
      CH_LD: begin
        grantAddr  = bus.ldAddr;
        grantWrite = 1'b1;
        grantData  = bus.ldD;
      end
      CH_VD: begin
        grantAddr  = bus.vdAddr;
        grantWrite = 1'b0;
        grantData  = 8'h00;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ACCESS;
      ACCESS:  if (waitCnt == 4'd0) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign laneByte = curLaneHi ? sramDq[15:8] : sramDq[7:0];

  // Access latch, wait-state down-counter and read capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      waitCnt   <= 4'd0;
      curCh     <= CH_LD;
      curWrite  <= 1'b0;
      curLaneHi <= 1'b0;
      curData   <= 8'h00;
      sramA     <= '0;
      vdQReg    <= 8'h00;
      cpuQReg   <= 8'h00;
    end else if (state == IDLE && anyReq) begin
      waitCnt   <= WAIT_LAST;
      curCh     <= grantCh;
      curWrite  <= grantWrite;
      curLaneHi <= grantAddr[0];
      curData   <= grantData;
      sramA     <= grantAddr[ADDR_WIDTH:1];
    end else if (state == ACCESS) begin
      if (waitCnt != 4'd0) begin
        waitCnt <= waitCnt - 4'd1;
      end else if (!curWrite) begin
        if (curCh == CH_VD)  vdQReg  <= laneByte;
        if (curCh == CH_CPU) cpuQReg <= laneByte;
      end
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Pointer moves to the other channel after every video or CPU grant
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      rrPtr <= 1'b0;
    else if (state == IDLE && anyReq && grantCh == CH_VD)
      rrPtr <= 1'b1;
    else if (state == IDLE && anyReq && grantCh == CH_CPU)
      rrPtr <= 1'b0;
  end
`endif

  // Output decode
  always_comb begin
    sramUb  = 1'b1;
    sramLb  = 1'b1;
    sramOe  = 1'b1;
    sramWe  = 1'b1;
    driveDq = 1'b0;
    ldAckC  = 1'b0;
    vdAckC  = 1'b0;
    cpuAckC = 1'b0;
    case (state)
      ACCESS: begin
        sramUb  = ~curLaneHi;
        sramLb  = curLaneHi;
        sramWe  = ~curWrite;
        sramOe  = curWrite;
        driveDq = curWrite;
      end
      DONE: begin
        sramUb  = ~curLaneHi;
        sramLb  = curLaneHi;
        driveDq = curWrite;
        ldAckC  = (curCh == CH_LD);
        vdAckC  = (curCh == CH_VD);
        cpuAckC = (curCh == CH_CPU);
      end
      default: ;
    endcase
  end

  // Byte written is replicated so either lane carries it
  assign sramDq     = driveDq ? {curData, curData} : 16'bz;
  assign bus.ldAck  = ldAckC;
  assign bus.vdAck  = vdAckC;
  assign bus.cpuAck = cpuAckC;
  assign bus.vdQ    = vdQReg;
  assign bus.cpuQ   = cpuQReg;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  localparam int AW = 21;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          sramUb, sramLb, sramOe, sramWe;
  logic [AW-1:0] sramA;
  wire  [15:0]   sramDq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  sram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  sram_arbiter #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .sramUb  (sramUb),
    .sramLb  (sramLb),
    .sramOe  (sramOe),
    .sramWe  (sramWe),
    .sramA   (sramA),
    .sramDq  (sramDq)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Small SRAM model: 64 words, byte-lane writes, drives bus when OE low
  logic [15:0] mem [0:63];
  bit          memReady;
  assign sramDq = (!sramOe) ? mem[sramA[5:0]] : 16'bz;

  always @(posedge clock) begin
    if (!memReady) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
      mem[16]  <= 16'h3C7E;
      memReady <= 1'b1;
    end else if (!sramWe) begin
      if (!sramLb) mem[sramA[5:0]][7:0]  <= sramDq[7:0];
      if (!sramUb) mem[sramA[5:0]][15:8] <= sramDq[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic ackOf(input int ch);
    case (ch)
      0:       return bus.ldAck;
      1:       return bus.vdAck;
      default: return bus.cpuAck;
    endcase
  endfunction

  task automatic waitAck(input string tag, input int ch, output int when);
    when = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ackOf(ch)) begin
        when = cyc;
        break;
      end
    end
    check({tag, "_seen"}, (when >= 0), 1);
  endtask

  task automatic waitAnyAck(output int id);
    id = 3;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ldAck)       begin id = 0; break; end
      else if (bus.vdAck)  begin id = 1; break; end
      else if (bus.cpuAck) begin id = 2; break; end
    end
  endtask

  int tReq, tL, tV, tC, id;
  int expSeq [4];

  initial begin
    bus.ldReq = 0; bus.ldAddr = '0; bus.ldD = 8'h00;
    bus.vdReq = 0; bus.vdAddr = '0;
    bus.cpuReq = 0; bus.cpuWe = 0; bus.cpuAddr = '0; bus.cpuD = 8'h00;

    // Reset state
    tick(); tick();
    check("rst_ub", sramUb, 1);
    check("rst_lb", sramLb, 1);
    check("rst_oe", sramOe, 1);
    check("rst_we", sramWe, 1);
    check("rst_a", sramA, 0);
    check("rst_acks", {bus.ldAck, bus.vdAck, bus.cpuAck}, 0);
    check("rst_q", {bus.vdQ, bus.cpuQ}, 0);
    reset_n = 1;
    tick();

    // Loader write to byte 3: upper lane of word 1
    bus.ldAddr = 22'h00003; bus.ldD = 8'hA5; bus.ldReq = 1;
    tReq = cyc;
    tick();
    bus.ldReq = 0;
    check("ld_a", sramA, 1);
    check("ld_ub", sramUb, 0);
    check("ld_lb", sramLb, 1);
    check("ld_we1", sramWe, 0);
    check("ld_oe", sramOe, 1);
    check("ld_dq", sramDq, 16'hA5A5);
    check("ld_noack", bus.ldAck, 0);
    tick();
    check("ld_we2", sramWe, 0);
    tick();
    check("ld_ack", bus.ldAck, 1);
    check("ld_lat", cyc - tReq, 3);
    check("ld_done_we", sramWe, 1);
    check("ld_done_dq", sramDq, 16'hA5A5);
    check("ld_other_acks", {bus.vdAck, bus.cpuAck}, 0);
    tick();
    check("ld_ack_pulse", bus.ldAck, 0);
    check("ld_idle_a", sramA, 1);
    check("ld_mem", mem[1], 16'hA500);

    // CPU reads of word 0x10, both lanes
    bus.cpuAddr = 22'h00020; bus.cpuWe = 0; bus.cpuReq = 1;
    tick();
    check("cr0_oe", sramOe, 0);
    check("cr0_we", sramWe, 1);
    check("cr0_a", sramA, 22'h10);
    check("cr0_lb", sramLb, 0);
    check("cr0_dq", sramDq, 16'h3C7E);
    waitAck("cr0", 2, tC);
    bus.cpuReq = 0;
    check("cr0_q", bus.cpuQ, 8'h7E);
    check("cr0_vdq", bus.vdQ, 0);
    tick();
    bus.cpuAddr = 22'h00021; bus.cpuReq = 1;
    tick();
    check("cr1_ub", sramUb, 0);
    check("cr1_q_hold", bus.cpuQ, 8'h7E);
    waitAck("cr1", 2, tC);
    bus.cpuReq = 0;
    check("cr1_q", bus.cpuQ, 8'h3C);

    // CPU write with request dropped and inputs changed mid-access
    tick();
    bus.cpuAddr = 22'h00005; bus.cpuD = 8'h99; bus.cpuWe = 1; bus.cpuReq = 1;
    tReq = cyc;
    tick();
    bus.cpuReq = 0; bus.cpuAddr = 22'h0003E; bus.cpuD = 8'h11; bus.cpuWe = 0;
    tick();
    check("cw_a_held", sramA, 2);
    check("cw_dq_held", sramDq, 16'h9999);
    tick();
    check("cw_ack", bus.cpuAck, 1);
    check("cw_lat", cyc - tReq, 3);
    tick();
    bus.cpuAddr = 22'h00005; bus.cpuWe = 0; bus.cpuReq = 1;
    waitAck("cwr", 2, tC);
    bus.cpuReq = 0;
    check("cwr_q", bus.cpuQ, 8'h99);
    tick();

    // All three requesters at one edge
    bus.ldAddr = 22'h00008; bus.ldD = 8'h42; bus.vdAddr = 22'h00020;
    bus.cpuAddr = 22'h00021; bus.cpuWe = 0;
    bus.ldReq = 1; bus.vdReq = 1; bus.cpuReq = 1;
    waitAck("all_ld", 0, tL);
    bus.ldReq = 0;
    waitAck("all_vd", 1, tV);
    bus.vdReq = 0;
    check("all_vdq", bus.vdQ, 8'h7E);
    waitAck("all_cpu", 2, tC);
    bus.cpuReq = 0;
    check("all_gap1", tV - tL, 4);
    check("all_gap2", tC - tV, 4);
    tick();

    // Continuous video + CPU contention
`ifdef SRAM_ARB_RR_EN
    expSeq = '{1, 2, 1, 2};
`else
    expSeq = '{1, 1, 1, 1};
`endif
    bus.vdReq = 1; bus.cpuReq = 1;
    for (int k = 0; k < 4; k++) begin
      waitAnyAck(id);
      check($sformatf("cont_%0d", k), id, expSeq[k]);
    end
    bus.vdReq = 0; bus.cpuReq = 0;
    tick(); tick();

    // Reset during second ACCESS cycle of a write
    bus.ldAddr = 22'h00010; bus.ldD = 8'h55; bus.ldReq = 1;
    tick();
    check("ra_we1", sramWe, 0);
    tick();
    check("ra_we2", sramWe, 0);
    #2 reset_n = 0;
    #1;
    check("ra_we_rst", sramWe, 1);
    check("ra_lb_rst", sramLb, 1);
    check("ra_a_rst", sramA, 0);
    check("ra_ack_rst", bus.ldAck, 0);
    bus.ldReq = 0;
    tick(); tick();
    reset_n = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("ra_quiet_%0d", k), {bus.ldAck, sramWe}, 2'b01);
    end
    bus.ldReq = 1;
    tReq = cyc;
    tick();
    bus.ldReq = 0;
    check("ra_new_we", sramWe, 0);
    tick(); tick();
    check("ra_new_ack", bus.ldAck, 1);
    check("ra_new_lat", cyc - tReq, 3);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
